// File: rtl/br_stats_mmio_if.sv
// Memory-mapped access port between the core's EX/DM stage and the
// branch-statistics block: address, store data, strobes, read data and select.
interface br_stats_mmio_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mm_we;
  logic        mm_re;
  logic [15:0] rdata;
  logic        sel;

  modport master (
    output addr, wdata, mm_we, mm_re,
    input  rdata, sel
  );

  modport slave (
    input  addr, wdata, mm_we, mm_re,
    output rdata, sel
  );
endinterface : br_stats_mmio_if

// File: rtl/br_stats_mmio.sv
// Branch-prediction statistics: four saturating 32-bit counters (branches,
// BTB hits, mispredicts, cycles) read as coherent LO/HI halves over MMIO.
module br_stats_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hC010,
  parameter int unsigned CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  br_stats_mmio_if.slave  bus,
  input  logic            inc_br_cnt,
  input  logic            inc_hit_cnt,
  input  logic            inc_mispr_cnt
);

  typedef enum logic [3:0] {
    OFF_CTRL     = 4'd0,
    OFF_BR_LO    = 4'd1,
    OFF_BR_HI    = 4'd2,
    OFF_HIT_LO   = 4'd3,
    OFF_HIT_HI   = 4'd4,
    OFF_MISPR_LO = 4'd5,
    OFF_MISPR_HI = 4'd6,
    OFF_CYC_LO   = 4'd7,
    OFF_CYC_HI   = 4'd8
  } reg_off_e;

  typedef enum int unsigned {
    IDX_BR    = 0,
    IDX_HIT   = 1,
    IDX_MISPR = 2,
    IDX_CYC   = 3
  } cnt_idx_e;

  if (CNT_W != 32) begin : g_bad_cnt_w
    $error("br_stats_mmio: CNT_W must be 32");
  end
  if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base_align
    $error("br_stats_mmio: BASE_ADDR[3:0] must be zero");
  end
  if (BASE_ADDR[15:13] == 3'b000) begin : g_bad_base_region
    $error("br_stats_mmio: BASE_ADDR must lie in the external region");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Adds one unless already pinned at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != CNT_MAX)) r = v + CNT_ONE;
    return r;
  endfunction

  logic [CNT_W-1:0] br_q,    br_d;
  logic [CNT_W-1:0] hit_q,   hit_d;
  logic [CNT_W-1:0] mispr_q, mispr_d;
  logic [CNT_W-1:0] cyc_q,   cyc_d;
  logic [3:0][15:0] shadow_q, shadow_d;
  logic             frozen_q, frozen_d;

  logic [3:0]  offset;
  logic        sel;
  logic        rd_en;
  logic        ctrl_wr;
  logic        clear;
  logic [15:0] rdata;
  logic        unused_wdata;

  assign offset       = bus.addr[3:0];
  assign sel          = (bus.addr[15:4] == BASE_ADDR[15:4]);
  assign rd_en        = bus.mm_re & sel;
  assign ctrl_wr      = bus.mm_we & sel & (offset == OFF_CTRL);
  assign clear        = ctrl_wr & bus.wdata[0];
  assign unused_wdata = ^bus.wdata[15:2];

  assign bus.sel   = sel;
  assign bus.rdata = rdata;

  // Clear beats freeze; freeze gates increments using the value stored
  // before this edge, so a CTRL write takes effect on the following cycle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    br_d     = br_q;
    hit_d    = hit_q;
    mispr_d  = mispr_q;
    cyc_d    = cyc_q;
    frozen_d = frozen_q;

    if (ctrl_wr) frozen_d = bus.wdata[1];

    if (clear) begin
      br_d    = '0;
      hit_d   = '0;
      mispr_d = '0;
      cyc_d   = '0;
    end else if (!frozen_q) begin
      br_d    = sat_inc(br_q,    inc_br_cnt);
      hit_d   = sat_inc(hit_q,   inc_hit_cnt);
      mispr_d = sat_inc(mispr_q, inc_mispr_cnt);
      cyc_d   = sat_inc(cyc_q,   1'b1);
    end
  end

  // A LO read latches the matching high half from the pre-increment value,
  // so the later HI read pairs with the LO data the core actually saw.
  always_comb begin
    shadow_d = shadow_q;
    if (clear) begin
      shadow_d = '0;
    end else if (rd_en) begin
      case (offset)
        OFF_BR_LO:    shadow_d[IDX_BR]    = br_q[CNT_W-1:16];
        OFF_HIT_LO:   shadow_d[IDX_HIT]   = hit_q[CNT_W-1:16];
        OFF_MISPR_LO: shadow_d[IDX_MISPR] = mispr_q[CNT_W-1:16];
        OFF_CYC_LO:   shadow_d[IDX_CYC]   = cyc_q[CNT_W-1:16];
        default:      ;
      endcase
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (rd_en) begin
      case (offset)
        OFF_CTRL:     rdata = {14'b0, frozen_q, 1'b0};
        OFF_BR_LO:    rdata = br_q[15:0];
        OFF_BR_HI:    rdata = shadow_q[IDX_BR];
        OFF_HIT_LO:   rdata = hit_q[15:0];
        OFF_HIT_HI:   rdata = shadow_q[IDX_HIT];
        OFF_MISPR_LO: rdata = mispr_q[15:0];
        OFF_MISPR_HI: rdata = shadow_q[IDX_MISPR];
        OFF_CYC_LO:   rdata = cyc_q[15:0];
        OFF_CYC_HI:   rdata = shadow_q[IDX_CYC];
        default:      rdata = 16'h0000;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q     <= '0;
      hit_q    <= '0;
      mispr_q  <= '0;
      cyc_q    <= '0;
      // NOTE: the shadow bank is reset as well; a HI read after reset must
      // return zero rather than a stale capture.
      shadow_q <= '0;
      frozen_q <= 1'b0;
    end else begin
      br_q     <= br_d;
      hit_q    <= hit_d;
      mispr_q  <= mispr_d;
      cyc_q    <= cyc_d;
      shadow_q <= shadow_d;
      frozen_q <= frozen_d;
    end
  end

endmodule : br_stats_mmio

// File: tb/tb_br_stats_mmio.sv
// Self-checking bench for br_stats_mmio: directed scenarios plus random traffic
// compared against an arithmetic model of the counters, shadows and CTRL.
module tb_br_stats_mmio;

  localparam logic [15:0] BASE = 16'hC010;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic clk;
  logic rst;
  logic inc_br_cnt, inc_hit_cnt, inc_mispr_cnt;

  br_stats_mmio_if bus ();

  br_stats_mmio #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .inc_br_cnt    (inc_br_cnt),
    .inc_hit_cnt   (inc_hit_cnt),
    .inc_mispr_cnt (inc_mispr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: counter values as plain integers, one shadow per counter
  // (0=BR, 1=HIT, 2=MISPR, 3=CYC), and the freeze flag.
  longint unsigned m_cnt [4];
  logic [15:0]     m_sh  [4];
  bit              m_frozen;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return a[15:4] == BASE[15:4];
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, input bit re);
    int off;
    off = int'(a[3:0]);
    if (!re || !in_win(a)) return 16'h0000;
    if (off == 0) return {14'b0, m_frozen, 1'b0};
    if (off >= 1 && off <= 8) begin
      if (off % 2 == 1) return m_cnt[(off - 1) / 2][15:0];
      return m_sh[(off - 2) / 2];
    end
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_sh[i]  = 16'h0000;
    end
    m_frozen = 1'b0;
  endtask

  task automatic model_edge(input bit r, input logic [15:0] a, input logic [15:0] wd,
                            input bit we, input bit re, input bit b, input bit h, input bit m);
    bit is_ctrl;
    int off;
    bit incs [4];
    if (r) begin
      model_reset();
      return;
    end
    off     = int'(a[3:0]);
    is_ctrl = we && in_win(a) && off == 0;
    if (re && in_win(a) && off >= 1 && off <= 7 && (off % 2 == 1))
      m_sh[(off - 1) / 2] = 16'(m_cnt[(off - 1) / 2] >> 16);
    incs[0] = b; incs[1] = h; incs[2] = m; incs[3] = 1'b1;
    if (!m_frozen)
      for (int i = 0; i < 4; i++)
        if (incs[i] && m_cnt[i] < MAXV) m_cnt[i] = m_cnt[i] + 1;
    if (is_ctrl && wd[0]) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0;
        m_sh[i]  = 16'h0000;
      end
    end
    if (is_ctrl) m_frozen = wd[1];
  endtask

  // One clock cycle: drive at the falling edge, check the combinational
  // outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle(input bit r, input logic [15:0] a, input logic [15:0] wd,
                       input bit we, input bit re, input bit b, input bit h, input bit m,
                       input string tag, output logic [15:0] rd);
    rst = r; bus.addr = a; bus.wdata = wd; bus.mm_we = we; bus.mm_re = re;
    inc_br_cnt = b; inc_hit_cnt = h; inc_mispr_cnt = m;
    #1;
    rd = bus.rdata;
    check({tag, "_sel"}, {15'b0, bus.sel}, {15'b0, in_win(a)});
    check({tag, "_rdata"}, bus.rdata, model_read(a, re));
    @(posedge clk);
    model_edge(r, a, wd, we, re, b, h, m);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [15:0] rd;
    for (int i = 0; i < n; i++) cycle(0, 16'h0000, 16'h0, 0, 0, 0, 0, 0, "idle", rd);
  endtask

  task automatic rd_reg(input int off, input string tag, output logic [15:0] rd);
    cycle(0, BASE | 16'(off), 16'h0, 0, 1, 0, 0, 0, tag, rd);
  endtask

  task automatic wr_ctrl(input logic [15:0] wd);
    logic [15:0] rd;
    cycle(0, BASE, wd, 1, 0, 0, 0, 0, "wr_ctrl", rd);
  endtask

  task automatic read_all(input string tag);
    logic [15:0] rd;
    for (int off = 0; off <= 8; off++) rd_reg(off, tag, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    rst = 1'b1; bus.addr = '0; bus.wdata = '0; bus.mm_we = 0; bus.mm_re = 0;
    inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0;
    model_reset();
    @(negedge clk);

    // Reset, then a readback of every register.
    cycle(1, 16'h0000, 16'h0, 0, 0, 0, 0, 0, "rst", rd);
    rd_reg(0, "rst_ctrl", rd);  check("rst_ctrl_const", rd, 16'h0000);
    rd_reg(2, "rst_br_hi", rd); check("rst_br_hi_const", rd, 16'h0000);

    // 5 branches, 3 of them with BTB hits, 2 mispredicts.
    cycle(1, 16'h0000, 16'h0, 0, 0, 0, 0, 0, "rst2", rd);
    cycle(0, 16'h0000, 16'h0, 0, 0, 1, 1, 0, "p1", rd);
    cycle(0, 16'h0000, 16'h0, 0, 0, 1, 1, 1, "p2", rd);
    cycle(0, 16'h0000, 16'h0, 0, 0, 1, 1, 0, "p3", rd);
    cycle(0, 16'h0000, 16'h0, 0, 0, 1, 0, 1, "p4", rd);
    cycle(0, 16'h0000, 16'h0, 0, 0, 1, 0, 0, "p5", rd);
    rd_reg(1, "cnt_br_lo", rd);    check("cnt_br_lo_const", rd, 16'd5);
    rd_reg(3, "cnt_hit_lo", rd);   check("cnt_hit_lo_const", rd, 16'd3);
    rd_reg(5, "cnt_mispr_lo", rd); check("cnt_mispr_lo_const", rd, 16'd2);
    rd_reg(2, "cnt_br_hi", rd);    check("cnt_br_hi_const", rd, 16'd0);
    rd_reg(4, "cnt_hit_hi", rd);
    rd_reg(6, "cnt_mispr_hi", rd);

    // Snapshot coherence across the 16-bit carry.
    force dut.br_q = 32'h0001_FFFF;
    m_cnt[0] = 64'h0001_FFFF;
    idle(1);
    release dut.br_q;
    cycle(0, BASE | 16'd1, 16'h0, 0, 1, 1, 0, 0, "snap_lo", rd); check("snap_lo_const", rd, 16'hFFFF);
    rd_reg(2, "snap_hi", rd);  check("snap_hi_const", rd, 16'h0001);
    rd_reg(1, "snap_lo2", rd); check("snap_lo2_const", rd, 16'h0000);
    rd_reg(2, "snap_hi2", rd); check("snap_hi2_const", rd, 16'h0002);

    // Saturation at all-ones.
    force dut.hit_q = 32'hFFFF_FFFE;
    m_cnt[1] = 64'hFFFF_FFFE;
    idle(1);
    release dut.hit_q;
    for (int i = 0; i < 3; i++) cycle(0, 16'h0000, 16'h0, 0, 0, 0, 1, 0, "sat_inc", rd);
    rd_reg(3, "sat_lo", rd); check("sat_lo_const", rd, 16'hFFFF);
    rd_reg(4, "sat_hi", rd); check("sat_hi_const", rd, 16'hFFFF);

    // Freeze, drop pulses, then clear.
    wr_ctrl(16'h0002);
    for (int i = 0; i < 10; i++) cycle(0, 16'h0000, 16'h0, 0, 0, 1, 1, 1, "frz_inc", rd);
    read_all("frz");
    rd_reg(0, "frz_ctrl", rd); check("frz_ctrl_const", rd, 16'h0002);
    wr_ctrl(16'h0001);
    rd_reg(0, "clr_ctrl", rd); check("clr_ctrl_const", rd, 16'h0000);
    rd_reg(1, "clr_br_lo", rd); check("clr_br_lo_const", rd, 16'h0000);
    rd_reg(7, "clr_cyc_lo_a", rd);
    rd_reg(7, "clr_cyc_lo_b", rd);

    // Clear with a same-cycle pulse (lost), then freeze+clear together.
    cycle(0, BASE, 16'h0001, 1, 0, 1, 1, 1, "clr_pulse", rd);
    cycle(0, 16'h0000, 16'h0, 0, 0, 1, 0, 0, "after_clr", rd);
    rd_reg(1, "after_clr_br", rd); check("after_clr_br_const", rd, 16'h0001);
    cycle(0, BASE, 16'h0003, 1, 0, 1, 1, 1, "frz_clr", rd);
    read_all("frz_clr");
    wr_ctrl(16'h0000);

    // Window decode, reserved offsets, ignored writes.
    cycle(0, 16'hC020, 16'h0, 0, 1, 0, 0, 0, "outside", rd); check("outside_const", rd, 16'h0000);
    rd_reg(9, "reserved", rd); check("reserved_const", rd, 16'h0000);
    rd_reg(15, "reserved_f", rd);
    cycle(0, BASE | 16'd1, 16'hFFFF, 1, 0, 0, 0, 0, "wr_br_lo", rd);
    cycle(0, 16'hC020, 16'h0003, 1, 0, 0, 0, 0, "wr_outside", rd);
    read_all("after_wr");

    // Reset between a LO and its HI read.
    idle(3);
    rd_reg(7, "cyc_lo_pre", rd);
    cycle(1, 16'h0000, 16'h0, 0, 0, 1, 1, 1, "mid_rst", rd);
    rd_reg(8, "cyc_hi_post", rd); check("cyc_hi_post_const", rd, 16'h0000);
    rd_reg(7, "cyc_lo_post", rd);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a, wd;
      bit r, we, re;
      a  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (BASE | 16'($urandom_range(0, 15)));
      wd = 16'($urandom);
      wd[0] = ($urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 7) == 0);
      re = $urandom_range(0, 1) == 1;
      r  = ($urandom_range(0, 199) == 0);
      cycle(r, a, wd, we, re, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, "rand", rd);
    end
    read_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_br_stats_mmio

// File: doc/br_stats_mmio.md
# br_stats_mmio

Memory-mapped branch-prediction statistics unit downstream of the CPU core. It counts the core's branch, BTB-hit and mispredict pulses plus elapsed cycles in four saturating 32-bit counters. Software reads them as 16-bit halves over the core's external memory-mapped port, with a snapshot mechanism that keeps each 32-bit read coherent. It sits beside the other external peripherals, and the top level selects its `rdata` whenever `sel` is high.

## Interface
- `BASE_ADDR`, default 16'hC010: base of the 16-word register window.
  - `BASE_ADDR[3:0]` must be 0.
  - `BASE_ADDR[15:13]` must be nonzero, so the core treats the window as external.
- `CNT_W`, default 32: counter width. Must be 32, because the register map exposes exactly LO/HI halves.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `addr`, input, 16: core memory-mapped address (EX/DM stage).
- `wdata`, input, 16: core store data.
- `mm_we`, input, 1: external write strobe, one cycle per store.
- `mm_re`, input, 1: external read strobe.
- `inc_br_cnt`, input, 1: one-cycle pulse when a branch resolves.
- `inc_hit_cnt`, input, 1: one-cycle pulse when a resolved branch had a BTB hit.
- `inc_mispr_cnt`, input, 1: one-cycle pulse on a mispredict.
- `rdata`, output, 16: combinational read data, valid in the same cycle as `mm_re`.
- `sel`, output, 1: combinational; high when `addr[15:4] == BASE_ADDR[15:4]`.

## Operation
- Register map, by offset `addr[3:0]`:
  - 0: CTRL.
  - 1/2: BR_LO/BR_HI.
  - 3/4: HIT_LO/HIT_HI.
  - 5/6: MISPR_LO/MISPR_HI.
  - 7/8: CYC_LO/CYC_HI.
  - 9–15: reserved; read 0, writes ignored.
- CTRL write, when `mm_we & sel & offset==0`:
  - `wdata[0]`=1 clears all four counters and all four shadows on that edge. It is a pulse, not stored.
  - `wdata[1]` is stored into `frozen`.
- CTRL read returns `{14'b0, frozen, 1'b0}`.
- Writes to offsets 1–15 have no effect.
- Counters:
  - When not frozen, BR, HIT and MISPR each add 1 on a cycle where their pulse is high. CYC adds 1 every cycle.
  - Each counter is independent; any combination of pulses may arrive in the same cycle.
  - Counters saturate at 32'hFFFF_FFFF and never wrap.
  - While `frozen`=1 all counters hold and pulses are dropped.
  - Priority, highest first: `rst` > clear > freeze > increment.
  - A CTRL write that sets freeze and clear together leaves counters at 0 and frozen.
- Snapshot:
  - An X_LO read returns `counter[15:0]` combinationally.
  - On the same edge, `shadow_X` captures `counter[31:16]`. These are the pre-increment values, consistent with the LO data returned.
  - An X_HI read returns `shadow_X`, never the live high half.
  - If the core holds `mm_re` on the same LO address across stall cycles, the shadow re-captures every cycle. The value the core commits is consistent with the last capture.
- `rdata` is 16'h0000 whenever `sel`=0 or `mm_re`=0.
- Reads have no side effects other than shadow capture.

## Timing
- Reset values (after an edge with `rst`=1):
  - All counters 0, all shadows 0, `frozen` 0.
  - `rdata` and `sel` are purely combinational and follow their inputs.
- Read latency is 0 cycles: `rdata` is valid in the same cycle as `mm_re`, as the core's dst mux requires.
- A counter read sees increments from all prior edges but not from the current cycle's pulse.
- CTRL write effects are visible on the cycle after the write edge.
- A pulse arriving in the same cycle as a clear is lost. A pulse in the cycle after the clear counts.
- Asserting `rst` mid-sequence (for example between a LO and its HI read) zeroes the shadows. A subsequent HI read returns 0.
- There is no handshake and no stall output; the block accepts one access per cycle.

## Test plan
- Reset, then 5 `inc_br_cnt` pulses, 3 `inc_hit_cnt`, 2 `inc_mispr_cnt` (hit and br pulsed together on 3 of the cycles) -> BR_LO=5, HIT_LO=3, MISPR_LO=2, all HI=0.
- Force BR to 32'h0001_FFFF, pulse `inc_br_cnt` in the same cycle as a BR_LO read, then read BR_HI -> LO returns FFFF, HI returns 0001, and a new LO read returns 0000 with HI 0002.
- Force HIT to 32'hFFFF_FFFE, pulse `inc_hit_cnt` 3 times -> LO=FFFF, HI=FFFF (saturated, no wrap).
- Write CTRL=16'h0002, pulse all incs for 10 cycles, then read -> counts unchanged and CTRL read=16'h0002. Write CTRL=16'h0001 -> all counters 0, CTRL read=0, CYC resumes counting.
- Read an address outside the window (16'hC020) and a reserved offset (BASE+9) -> `sel`=0 with `rdata`=0 for the first; `sel`=1 with `rdata`=0 for the second. A write to BR_LO leaves BR unchanged.
- Read CYC_LO, assert `rst` for one cycle, then read CYC_HI -> returns 0000, and CYC_LO restarts from 0.
